// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: opcode values, opcode classes and sequencer state encoding.
// Used by the control unit and by later decode/hazard logic.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_UNARY,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT
  } state_t;

endpackage

// File: rtl/cu_op_class.sv
// Combinational opcode classifier: 5-bit opcode to instruction class.
module cu_op_class
  import cpu_pkg::*;
(
  input  logic [4:0] op,
  output logic [2:0] cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls = CLS_RTYPE;
      OP_NEG, OP_NOT:                  cls = CLS_UNARY;
      OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
      OP_NOP:                          cls = CLS_NOP;
      OP_HALT:                         cls = CLS_HALT;
      default:                         cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, execute T3-T6, halt on HALT opcode or Stop.
// Outputs decode from state plus IR opcode, so clear drops them without a clock edge.
module control_unit
  import cpu_pkg::*;
#(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic [IR_W-1:0] IR,
  input  logic            Stop,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [OP_W-1:0] opcode,
  output logic            Run,
  output logic            illegal
);

  state_t          state;
  state_t          ret_state;
  logic [OP_W-1:0] ir_op;
  logic [2:0]      cls;
  logic            unused_ir;

  assign ir_op     = IR[IR_W-1 -: OP_W];
  assign unused_ir = ^IR[IR_W-OP_W-1:0];

  cu_op_class u_op_class (
    .op  (ir_op),
    .cls (cls)
  );

  // Every execute path returns here; Stop only matters on this edge.
  assign ret_state = Stop ? ST_HALT : ST_T0;

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state <= ST_RST;
    end else begin
      case (state)
        ST_RST:  state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   state <= ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3: begin
          if (cls == CLS_RTYPE || cls == CLS_UNARY || cls == CLS_MULDIV)
            state <= ST_T4;
          else if (cls == CLS_HALT)
            state <= ST_HALT;
          else
            state <= ret_state;
        end
        ST_T4:   state <= (cls == CLS_RTYPE || cls == CLS_MULDIV) ? ST_T5 : ret_state;
        ST_T5:   state <= (cls == CLS_MULDIV) ? ST_T6 : ret_state;
        ST_T6:   state <= ret_state;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RST;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0;
    PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    opcode = '0; illegal = 1'b0;
    Run = (state != ST_RST) && (state != ST_HALT);
    case (state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_RTYPE:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_UNARY:   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_op; end
          CLS_MULDIV:  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_RTYPE:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_op; end
          CLS_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_op; end
          default: ;
        endcase
      end
      ST_T5: begin
        if (cls == CLS_RTYPE) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end
      end
      ST_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instructions plus randomized instruction stream.
module tb_control_unit;

  logic        Clock, clear, Stop;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, PCin, MARin, MDRin, IRin;
  logic Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, illegal;
  logic [4:0] opcode;

  typedef struct packed {
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, PCin, MARin, MDRin, IRin;
    logic Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
    logic [4:0] opcode;
    logic Run, illegal;
  } outs_t;

  outs_t obs;
  assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, PCin, MARin, MDRin, IRin,
                Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
                opcode, Run, illegal};

  int n_checks = 0;
  int n_fail   = 0;
  outs_t exp_q[$];

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
    .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .opcode(opcode), .Run(Run), .illegal(illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // 0 rtype, 1 unary, 2 muldiv, 3 nop, 4 halt, 5 illegal
  function automatic int cls_of(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: return 0;
      5'b10001, 5'b10010:                     return 1;
      5'b01111, 5'b10000:                     return 2;
      5'b11010:                               return 3;
      5'b11011:                               return 4;
      default:                                return 5;
    endcase
  endfunction

  function automatic outs_t t0_vec();
    outs_t o = '0;
    o.Run = 1'b1; o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.Zin = 1'b1;
    return o;
  endfunction

  // Expected per-cycle outputs for one instruction, starting at T0.
  task automatic build_exp(input logic [31:0] ir);
    outs_t o;
    logic [4:0] op = ir[31:27];
    exp_q.delete();
    exp_q.push_back(t0_vec());
    o = '0; o.Run = 1; o.Zlowout = 1; o.PCin = 1; o.Read = 1; o.MDRin = 1; exp_q.push_back(o);
    o = '0; o.Run = 1; o.MDRout = 1; o.IRin = 1; exp_q.push_back(o);
    case (cls_of(op))
      0: begin
        o = '0; o.Run = 1; o.Grb = 1; o.Rout = 1; o.Yin = 1; exp_q.push_back(o);
        o = '0; o.Run = 1; o.Grc = 1; o.Rout = 1; o.Zin = 1; o.opcode = op; exp_q.push_back(o);
        o = '0; o.Run = 1; o.Zlowout = 1; o.Gra = 1; o.Rin = 1; exp_q.push_back(o);
      end
      1: begin
        o = '0; o.Run = 1; o.Grb = 1; o.Rout = 1; o.Zin = 1; o.opcode = op; exp_q.push_back(o);
        o = '0; o.Run = 1; o.Zlowout = 1; o.Gra = 1; o.Rin = 1; exp_q.push_back(o);
      end
      2: begin
        o = '0; o.Run = 1; o.Gra = 1; o.Rout = 1; o.Yin = 1; exp_q.push_back(o);
        o = '0; o.Run = 1; o.Grb = 1; o.Rout = 1; o.Zin = 1; o.opcode = op; exp_q.push_back(o);
        o = '0; o.Run = 1; o.Zlowout = 1; o.LOin = 1; exp_q.push_back(o);
        o = '0; o.Run = 1; o.Zhighout = 1; o.HIin = 1; exp_q.push_back(o);
      end
      5: begin
        o = '0; o.Run = 1; o.illegal = 1; exp_q.push_back(o);
      end
      default: begin
        o = '0; o.Run = 1; exp_q.push_back(o);
      end
    endcase
  endtask

  // Called at posedge+1 of a T0 cycle. stop_mode: 0 none, 1 Stop pulse in T1 only,
  // 2 Stop held from cycle stop_k to the end. Leaves the bench at posedge+1 of the next state.
  task automatic run_instr(input string name, input logic [31:0] ir, input int stop_mode,
                           input int stop_k, output logic halted);
    outs_t want;
    IR = ir;
    build_exp(ir);
    halted = (cls_of(ir[31:27]) == 4) || (stop_mode == 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      Stop = (stop_mode == 1 && i == 1) || (stop_mode == 2 && i >= stop_k);
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s ir=%h step %0d: got %h want %h", name, ir, i, obs, exp_q[i]);
      end
      @(posedge Clock); #1;
    end
    Stop = 1'b0;
    want = halted ? outs_t'('0) : t0_vec();
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s_end ir=%h: got %h want %h", name, ir, obs, want);
    end
  endtask

  // Asynchronous clear pulse, then release; ends at posedge+1 of T0.
  task automatic do_clear(input string name);
    clear = 1'b1;
    #1;
    n_checks++;
    if (obs !== outs_t'('0)) begin
      n_fail++; $display("FAIL %s_async: got %h want 0", name, obs);
    end
    @(posedge Clock); #1;
    clear = 1'b0;
    #1;
    n_checks++;
    if (obs !== outs_t'('0)) begin
      n_fail++; $display("FAIL %s_rst: got %h want 0", name, obs);
    end
    @(posedge Clock); #1;
    n_checks++;
    if (obs !== t0_vec()) begin
      n_fail++; $display("FAIL %s_t0: got %h want %h", name, obs, t0_vec());
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; Stop = 1'b0; IR = '0;
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if (obs !== outs_t'('0)) begin
      n_fail++; $display("FAIL reset: got %h want 0", obs);
    end
    do_clear("reset");
  endtask

  task automatic test_rtype();
    logic h;
    run_instr("rtype_and", 32'h28918000, 0, 0, h);
    run_instr("rtype_ror", 32'h53300000, 0, 0, h);
  endtask

  task automatic test_muldiv();
    logic h;
    run_instr("mul", 32'h79980000, 0, 0, h);
  endtask

  task automatic test_illegal();
    logic h;
    run_instr("illegal", 32'hF8000000, 0, 0, h);
  endtask

  task automatic test_halt();
    logic h;
    run_instr("halt", 32'hD8000000, 0, 0, h);
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); #1;
      n_checks++;
      if (obs !== outs_t'('0)) begin
        n_fail++; $display("FAIL halt_idle cycle %0d: got %h want 0", i, obs);
      end
    end
    do_clear("halt_clear");
  endtask

  task automatic test_clear_mid();
    IR = 32'h28918000;
    repeat (4) @(posedge Clock);
    #3;
    do_clear("clear_mid");
  endtask

  task automatic test_stop();
    logic h;
    run_instr("stop_t4", 32'h28918000, 2, 4, h);
    do_clear("stop_clear");
    run_instr("stop_fetch_pulse", 32'h28918000, 1, 0, h);
  endtask

  task automatic test_back_to_back();
    logic h;
    logic [31:0] ir;
    int mode, k;
    for (int n = 0; n < 80; n++) begin
      ir = $urandom;
      mode = $urandom_range(0, 5);
      if (mode > 2) mode = 0;
      build_exp(ir);
      k = $urandom_range(0, exp_q.size() - 1);
      run_instr("random", ir, mode, k, h);
      if (h) do_clear("random_clear");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_muldiv();
    test_illegal();
    test_halt();
    test_clear_mid();
    test_stop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
